pico_bram_banked_bridge: RTL and testbench

Parametrised successor bridge between the PicoRV32 native memory interface and one or more Xilinx BRAM ports. Decodes the address onto C_NUM_BANKS contiguous BRAM banks, supports configurable BRAM read latency (output-register pipelines), and completes unmapped accesses with an error response instead of hanging the core. Sits between the PicoRV32 core and the BRAM controllers in the processor subsystem.

---
 rtl/pico_bram_banked_bridge.sv | 153 +++++++++++++++
 tb/tb_pico_bram_banked_bridge.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_bram_banked_bridge.sv
// PicoRV32 native memory bus to banked Xilinx BRAM bridge.
// The address window is split into C_NUM_BANKS contiguous banks. Reads wait
// out the BRAM output-register pipeline. Accesses outside the window complete
// with an error response so the core never stalls forever.
module pico_bram_banked_bridge #(
  parameter int          C_NUM_BANKS       = 2,
  parameter int          C_BANK_ADDR_WIDTH = 13,
  parameter logic [31:0] C_BASE_ADDR       = 32'h0000_0000,
  parameter int          C_RD_LATENCY      = 1,
  parameter logic [31:0] C_ERR_DATA        = 32'hDEAD_BEEF
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     MEM_VALID,
  input  logic                                     MEM_INSTR,
  output logic                                     MEM_READY,
  input  logic [31:0]                              MEM_ADDR,
  input  logic [31:0]                              MEM_WDATA,
  input  logic [3:0]                               MEM_WSTRB,
  output logic [31:0]                              MEM_RDATA,
  output logic                                     BRAM_CLK,
  output logic                                     BRAM_RST,
  output logic [C_NUM_BANKS*C_BANK_ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [32*C_NUM_BANKS-1:0]                BRAM_DIN,
  input  logic [32*C_NUM_BANKS-1:0]                BRAM_DOUT,
  output logic [C_NUM_BANKS-1:0]                   BRAM_EN,
  output logic [4*C_NUM_BANKS-1:0]                 BRAM_WE,
  output logic                                     ERR,
  output logic [31:0]                              ERR_ADDR,
  output logic [7:0]                               ERR_COUNT
);

  localparam int          BW   = (C_NUM_BANKS > 1) ? $clog2(C_NUM_BANKS) : 1;
  localparam logic [32:0] SPAN = 33'(C_NUM_BANKS) << C_BANK_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, ERR_RESP} state_t;

  state_t                       state_q;
  logic [BW-1:0]                bank_q;
  logic [C_BANK_ADDR_WIDTH-1:0] addr_q;
  logic                         rd_q;
  logic [2:0]                   cnt_q;
  logic [31:0]                  err_addr_q;
  logic [7:0]                   err_cnt_q;

  logic [31:0]   offset;
  logic          hit;
  logic [BW-1:0] bank;
  logic          unused_instr;

  // The instruction flag carries no meaning for a plain memory bridge.
  assign unused_instr = MEM_INSTR;

  assign BRAM_CLK  = CLK;
  assign BRAM_RST  = RST;
  assign BRAM_DIN  = {C_NUM_BANKS{MEM_WDATA}};
  assign ERR_ADDR  = err_addr_q;
  assign ERR_COUNT = err_cnt_q;

  // Window decode: subtraction wraps, so addresses below the base land far above the span.
  always_comb begin
    offset = MEM_ADDR - C_BASE_ADDR;
    hit    = {1'b0, offset} < SPAN;
    bank   = '0;
    if (C_NUM_BANKS > 1) bank = offset[C_BANK_ADDR_WIDTH +: BW];
  end

  // Bank strobes and response outputs follow the state; IDLE drives the issue cycle directly.
  always_comb begin
    BRAM_EN   = '0;
    BRAM_WE   = '0;
    BRAM_ADDR = '0;
    MEM_READY = 1'b0;
    MEM_RDATA = '0;
    ERR       = 1'b0;
    for (int b = 0; b < C_NUM_BANKS; b++) begin
      BRAM_ADDR[b*C_BANK_ADDR_WIDTH +: C_BANK_ADDR_WIDTH] =
        (state_q == IDLE) ? offset[C_BANK_ADDR_WIDTH-1:0] : addr_q;
    end
    case (state_q)
      IDLE: begin
        if (MEM_VALID && hit) begin
          for (int b = 0; b < C_NUM_BANKS; b++) begin
            if (bank == BW'(b)) begin
              BRAM_EN[b]       = 1'b1;
              BRAM_WE[b*4 +: 4] = MEM_WSTRB;
            end
          end
        end
      end
      RD_WAIT: begin
        for (int b = 0; b < C_NUM_BANKS; b++) begin
          if (bank_q == BW'(b)) BRAM_EN[b] = 1'b1;
        end
      end
      RESP: begin
        MEM_READY = 1'b1;
        if (rd_q) begin
          for (int b = 0; b < C_NUM_BANKS; b++) begin
            if (bank_q == BW'(b)) MEM_RDATA = BRAM_DOUT[b*32 +: 32];
          end
        end
      end
      ERR_RESP: begin
        MEM_READY = 1'b1;
        ERR       = 1'b1;
        MEM_RDATA = rd_q ? C_ERR_DATA : 32'h0;
      end
      default: ;
    endcase
  end

  // Transaction FSM: requests are captured only in IDLE and always run to completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      cnt_q      <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MEM_VALID) begin
            rd_q   <= (MEM_WSTRB == 4'h0);
            bank_q <= bank;
            addr_q <= offset[C_BANK_ADDR_WIDTH-1:0];
            if (!hit) begin
              state_q    <= ERR_RESP;
              err_addr_q <= MEM_ADDR;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (MEM_WSTRB != 4'h0) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= 3'(C_RD_LATENCY - 1);
              state_q <= (C_RD_LATENCY == 1) ? RESP : RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= RESP;
        end
        RESP:     state_q <= IDLE;
        ERR_RESP: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_bram_banked_bridge.sv
// Testbench for pico_bram_banked_bridge.
// Two bridges run side by side: instance 0 uses the default parameters,
// instance 1 uses a three-cycle read latency and a base of 0x1000_0000.
// Each bridge drives its own behavioural BRAM, and expected results come
// from a flat word-addressed reference memory plus simple address arithmetic.
module tb_pico_bram_banked_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid   [2];
  logic        instr   [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        ready   [2];
  logic [31:0] rdata   [2];
  logic        bclk    [2];
  logic        brst    [2];
  logic [25:0] baddr   [2];
  logic [63:0] bdin    [2];
  logic [63:0] bdout   [2];
  logic [1:0]  ben     [2];
  logic [7:0]  bwe     [2];
  logic        err     [2];
  logic [31:0] errAddr [2];
  logic [7:0]  errCount[2];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] refMem [int];
  int          errCntModel  [2];
  logic [31:0] errAddrModel [2];

  // Free-running clock shared by both bridges.
  always #5 clk = ~clk;

  pico_bram_banked_bridge dut0 (
    .CLK(clk), .RST(rst), .MEM_VALID(valid[0]), .MEM_INSTR(instr[0]),
    .MEM_READY(ready[0]), .MEM_ADDR(addr[0]), .MEM_WDATA(wdata[0]),
    .MEM_WSTRB(wstrb[0]), .MEM_RDATA(rdata[0]), .BRAM_CLK(bclk[0]),
    .BRAM_RST(brst[0]), .BRAM_ADDR(baddr[0]), .BRAM_DIN(bdin[0]),
    .BRAM_DOUT(bdout[0]), .BRAM_EN(ben[0]), .BRAM_WE(bwe[0]), .ERR(err[0]),
    .ERR_ADDR(errAddr[0]), .ERR_COUNT(errCount[0])
  );

  pico_bram_banked_bridge #(
    .C_RD_LATENCY(3),
    .C_BASE_ADDR (32'h1000_0000)
  ) dut1 (
    .CLK(clk), .RST(rst), .MEM_VALID(valid[1]), .MEM_INSTR(instr[1]),
    .MEM_READY(ready[1]), .MEM_ADDR(addr[1]), .MEM_WDATA(wdata[1]),
    .MEM_WSTRB(wstrb[1]), .MEM_RDATA(rdata[1]), .BRAM_CLK(bclk[1]),
    .BRAM_RST(brst[1]), .BRAM_ADDR(baddr[1]), .BRAM_DIN(bdin[1]),
    .BRAM_DOUT(bdout[1]), .BRAM_EN(ben[1]), .BRAM_WE(bwe[1]), .ERR(err[1]),
    .ERR_ADDR(errAddr[1]), .ERR_COUNT(errCount[1])
  );

  // Behavioural BRAM per bridge: read-first array feeding an enable-gated
  // output pipeline whose depth equals that bridge's read latency.
  for (genvar g = 0; g < 2; g++) begin : gBram
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] mem  [2][2048];
    logic [31:0] pipe [2][L];

    always @(posedge clk) begin
      int idx;
      for (int b = 0; b < 2; b++) begin
        if (ben[g][b]) begin
          idx = int'(baddr[g][b*13 +: 13]) >> 2;
          pipe[b][0] <= mem[b][idx];
          for (int k = 1; k < L; k++) pipe[b][k] <= pipe[b][k-1];
          for (int j = 0; j < 4; j++) begin
            if (bwe[g][b*4+j]) mem[b][idx][8*j +: 8] <= bdin[g][b*32 + 8*j +: 8];
          end
        end
      end
    end

    assign bdout[g] = {pipe[1][L-1], pipe[0][L-1]};
  end

  // One complete bus transaction on bridge d, checked cycle by cycle against
  // the window arithmetic and the reference memory.
  task automatic doTxn(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] got);
    logic [31:0] base, off, expData;
    logic [1:0]  expEn;
    logic [7:0]  expWe;
    logic        hit, isRead, done;
    int          bank, lo, lat, expCyc, cyc, key;
    base   = (d == 0) ? 32'h0000_0000 : 32'h1000_0000;
    lat    = (d == 0) ? 1 : 3;
    off    = a - base;
    hit    = off < 32'h0000_4000;
    bank   = int'(off / 32'd8192);
    lo     = int'(off % 32'd8192);
    key    = d * 65536 + int'(off >> 2);
    isRead = (ws == 4'h0);
    expCyc = (hit && isRead) ? lat : 1;
    expEn  = hit ? (2'b01 << bank) : 2'b00;
    expWe  = hit ? (8'(ws) << (4 * bank)) : 8'h00;
    if (!hit)        expData = isRead ? 32'hDEAD_BEEF : 32'h0;
    else if (!isRead) expData = 32'h0;
    else             expData = refMem.exists(key) ? refMem[key] : 32'h0;
    got = 32'h0;

    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws; instr[d] = 1'($urandom);
    #1;
    checks++;
    if (ben[d] !== expEn || bwe[d] !== expWe) begin
      failures++;
      $display("[TB] FAIL issue_strobes d%0d a=%h: en=%b we=%b, expected en=%b we=%b",
               d, a, ben[d], bwe[d], expEn, expWe);
    end
    checks++;
    if (ready[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL issue_idle_outputs d%0d: ready=%b rdata=%h err=%b, expected 0",
               d, ready[d], rdata[d], err[d]);
    end
    if (hit) begin
      checks++;
      if (baddr[d][bank*13 +: 13] !== 13'(lo)) begin
        failures++;
        $display("[TB] FAIL issue_addr d%0d: got %h expected %h", d, baddr[d][bank*13 +: 13], 13'(lo));
      end
    end

    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
      // Inputs are scrambled mid-flight; the bridge must ignore them.
      addr[d] = $urandom; wdata[d] = $urandom; wstrb[d] = 4'($urandom);
      #1;
      if (ready[d] === 1'b1) begin
        done = 1'b1;
        got  = rdata[d];
        checks++;
        if (cyc != expCyc) begin
          failures++;
          $display("[TB] FAIL ready_cycle d%0d a=%h: got %0d expected %0d", d, a, cyc, expCyc);
        end
        checks++;
        if (rdata[d] !== expData || err[d] !== !hit) begin
          failures++;
          $display("[TB] FAIL response d%0d a=%h: rdata=%h err=%b, expected rdata=%h err=%b",
                   d, a, rdata[d], err[d], expData, !hit);
        end
        checks++;
        if (ben[d] !== 2'b00 || bwe[d] !== 8'h00) begin
          failures++;
          $display("[TB] FAIL resp_strobes d%0d: en=%b we=%b expected 0", d, ben[d], bwe[d]);
        end
      end else begin
        checks++;
        if (ben[d] !== ((hit && isRead && cyc < lat) ? expEn : 2'b00) || bwe[d] !== 8'h00
            || err[d] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL wait_strobes d%0d cyc%0d: en=%b we=%b err=%b", d, cyc, ben[d], bwe[d], err[d]);
        end
        if (hit && isRead && cyc < lat) begin
          checks++;
          if (baddr[d][bank*13 +: 13] !== 13'(lo)) begin
            failures++;
            $display("[TB] FAIL wait_addr d%0d: got %h expected %h", d, baddr[d][bank*13 +: 13], 13'(lo));
          end
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout d%0d a=%h: no MEM_READY within 12 cycles", d, a);
    end
    valid[d] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready[d] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_width d%0d: ready=%b expected 0", d, ready[d]);
    end

    if (!hit) begin
      if (errCntModel[d] < 255) errCntModel[d]++;
      errAddrModel[d] = a;
    end else if (!isRead) begin
      logic [31:0] w;
      w = refMem.exists(key) ? refMem[key] : 32'h0;
      for (int j = 0; j < 4; j++) if (ws[j]) w[8*j +: 8] = wd[8*j +: 8];
      refMem[key] = w;
    end
    checks++;
    if (errCount[d] !== 8'(errCntModel[d]) || errAddr[d] !== errAddrModel[d]) begin
      failures++;
      $display("[TB] FAIL err_regs d%0d: count=%0d addr=%h, expected count=%0d addr=%h",
               d, errCount[d], errAddr[d], errCntModel[d], errAddrModel[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; instr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      errCntModel[d] = 0; errAddrModel[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b0 || rdata[d] !== 32'h0 || ben[d] !== 2'b00 || bwe[d] !== 8'h00
          || err[d] !== 1'b0 || errAddr[d] !== 32'h0 || errCount[d] !== 8'h00 || brst[d] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_values d%0d: ready=%b rdata=%h en=%b we=%b err=%b eaddr=%h ecnt=%0d brst=%b",
                 d, ready[d], rdata[d], ben[d], bwe[d], err[d], errAddr[d], errCount[d], brst[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (brst[0] !== 1'b0 || bclk[0] !== clk || bclk[1] !== clk) begin
      failures++;
      $display("[TB] FAIL bram_clk_rst: brst=%b bclk=%b/%b expected 0/%b", brst[0], bclk[0], bclk[1], clk);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] got;
    doTxn(0, 32'h0000_0004, 32'h1234_5678, 4'hF, got);
    doTxn(0, 32'h0000_2008, 32'hCAFE_0001, 4'hF, got);
    doTxn(0, 32'h0000_2008, 32'h0, 4'h0, got);
    checks++;
    if (got !== 32'hCAFE_0001) begin
      failures++;
      $display("[TB] FAIL read_bank1: got %h expected %h", got, 32'hCAFE_0001);
    end
    doTxn(0, 32'h0000_0004, 32'h0, 4'h0, got);
    checks++;
    if (got !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL read_bank0: got %h expected %h", got, 32'h1234_5678);
    end
  endtask

  task automatic test_latency();
    logic [31:0] got;
    doTxn(1, 32'h1000_0010, 32'hA5A5_0010, 4'hF, got);
    doTxn(1, 32'h1000_0010, 32'h0, 4'h0, got);
    checks++;
    if (got !== 32'hA5A5_0010) begin
      failures++;
      $display("[TB] FAIL latency3_read: got %h expected %h", got, 32'hA5A5_0010);
    end
  endtask

  task automatic test_errors();
    logic [31:0] got;
    doTxn(0, 32'h0000_4000, 32'h0, 4'h0, got);
    checks++;
    if (got !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL err_read_data: got %h expected %h", got, 32'hDEAD_BEEF);
    end
    doTxn(0, 32'h8000_0000, 32'h1111_2222, 4'hF, got);
    checks++;
    if (errCount[0] !== 8'd2 || errAddr[0] !== 32'h8000_0000 || got !== 32'h0) begin
      failures++;
      $display("[TB] FAIL err_two_misses: count=%0d addr=%h rdata=%h expected 2 80000000 0",
               errCount[0], errAddr[0], got);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] got, a;
    for (int i = 0; i < 300; i++) begin
      a = 32'h0000_4000 + ($urandom % 32'hFFFF_B000);
      doTxn(0, a, $urandom, 4'($urandom), got);
    end
    checks++;
    if (errCount[0] !== 8'd255) begin
      failures++;
      $display("[TB] FAIL err_saturate: got %0d expected 255", errCount[0]);
    end
  endtask

  task automatic test_base_addr();
    logic [31:0] got;
    doTxn(1, 32'h1000_2002, 32'h00AB_0000, 4'b0100, got);
    doTxn(1, 32'h1000_2000, 32'h0, 4'h0, got);
    checks++;
    if (got[23:16] !== 8'hAB) begin
      failures++;
      $display("[TB] FAIL base_lane2: got %h expected AB", got[23:16]);
    end
    doTxn(1, 32'h0FFF_FFFC, 32'h0, 4'h0, got);
    doTxn(1, 32'h1000_3FFC, 32'h7777_8888, 4'hF, got);
    doTxn(1, 32'h1000_4000, 32'h0, 4'h0, got);
    checks++;
    if (errAddr[1] !== 32'h1000_4000 || errCount[1] !== 8'd2) begin
      failures++;
      $display("[TB] FAIL base_bounds: addr=%h count=%0d expected 10004000 2", errAddr[1], errCount[1]);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] got;
    logic        sawReady;
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h1000_0010; wstrb[1] = 4'h0;
    @(posedge clk); #1;
    rst = 1'b1; valid[1] = 1'b0;
    #1;
    checks++;
    if (ben[1] !== 2'b00 || ready[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midflight_reset_now: en=%b ready=%b expected 0 0", ben[1], ready[1]);
    end
    sawReady = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready[1] !== 1'b0) sawReady = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    errCntModel[0] = 0; errCntModel[1] = 0;
    errAddrModel[0] = '0; errAddrModel[1] = '0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready[1] !== 1'b0) sawReady = 1'b1;
    end
    checks++;
    if (sawReady) begin
      failures++;
      $display("[TB] FAIL midflight_no_ready: ready seen=1 expected 0");
    end
    doTxn(1, 32'h1000_0010, 32'h0, 4'h0, got);
    checks++;
    if (got !== 32'hA5A5_0010) begin
      failures++;
      $display("[TB] FAIL midflight_recover: got %h expected %h", got, 32'hA5A5_0010);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, a, base, off;
    int          words [8] = '{0, 1, 2, 3, 2044, 2045, 2046, 2047};
    for (int d = 0; d < 2; d++) begin
      base = (d == 0) ? 32'h0 : 32'h1000_0000;
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < 8; w++)
          doTxn(d, base + 32'(b * 8192 + words[w] * 4), $urandom, 4'hF, got);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 9) < 7) begin
          a = base + 32'($urandom_range(0, 1) * 8192 + words[$urandom_range(0, 7)] * 4);
        end else begin
          a = $urandom;
          off = a - base;
          while (off < 32'h4000) begin
            a = $urandom;
            off = a - base;
          end
        end
        doTxn(d, a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), got);
      end
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_errors();
    test_saturation();
    test_base_addr();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
